// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, twiddle Q-format constants,
// complex sample type and the round-to-nearest bias helper.
package fft_pkg;

  localparam int DATA_W_DEF  = 25;
  localparam int TW_W_DEF    = 18;
  localparam int TW_FRAC_DEF = TW_W_DEF - 1;

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] re;
    logic signed [DATA_W_DEF-1:0] im;
  } cplx_t;

  // Half an LSB of the result when dropping `shift` fraction bits.
  function automatic logic [63:0] round_bias(input int unsigned shift);
    logic [63:0] bias;
    if (shift == 32'd0) begin
      bias = 64'd0;
    end else begin
      bias = 64'd1 << (shift - 32'd1);
    end
    return bias;
  endfunction

endpackage

// File: rtl/fft_cmult_pipe_round_sat.sv
// fft_round_sat: combinational round-half-up, arithmetic shift and width reduction.
// Build option FFT_CMULT_SAT_EN clamps on overflow; otherwise the low bits wrap.
module fft_round_sat
  import fft_pkg::*;
#(
  parameter int P     = DATA_W_DEF + TW_W_DEF + 1,
  parameter int SHIFT = TW_FRAC_DEF,
  parameter int OUT_W = DATA_W_DEF
) (
  input  logic signed [P-1:0]     val_i,
  output logic        [OUT_W-1:0] res_o,
  output logic                    ovf_o
);

  // Shifted width must be at least OUT_W so the range check has a sign column.
  localparam int R_W = P - SHIFT;

  logic signed [P-1:0]       biased_s;
  logic signed [R_W-1:0]     shifted_s;
  logic        [R_W-OUT_W:0] hi_s;

  // Round, shift, and flag values whose upper bits are not a pure sign extension.
  always_comb begin
    biased_s  = val_i + $signed(P'(round_bias(SHIFT)));
    shifted_s = biased_s[P-1:SHIFT];
    hi_s      = shifted_s[R_W-1:OUT_W-1];
    ovf_o     = ~((&hi_s) | ~(|hi_s));
`ifdef FFT_CMULT_SAT_EN
    if (ovf_o) begin
      res_o = shifted_s[R_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      res_o = shifted_s[OUT_W-1:0];
    end
`else
    res_o = shifted_s[OUT_W-1:0];
`endif
  end

endmodule

// File: rtl/fft_cmult_pipe.sv
// Four-stage pipelined complex multiplier: sample times twiddle (or its conjugate),
// with valid/ready flow control. Build option FFT_CMULT_SAT_EN: saturate instead of wrap.
module fft_cmult_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF,
  parameter int OUT_W  = DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2*DATA_W-1:0]   data_i,
  input  logic [2*TW_W-1:0]     tw_i,
  input  logic                  conj_i,
  input  logic                  last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [2*OUT_W-1:0]    data_o,
  output logic                  last_o,
  output logic                  ovf_o,
  input  logic                  clr_ovf_i
);

  localparam int PP_W = DATA_W + TW_W;
  localparam int P    = DATA_W + TW_W + 1;

  logic en_s;

  logic                     s1_valid_q, s1_valid_d, s1_conj_q, s1_conj_d, s1_last_q, s1_last_d;
  logic signed [DATA_W-1:0] s1_ar_q, s1_ar_d, s1_ai_q, s1_ai_d;
  logic signed [TW_W-1:0]   s1_wr_q, s1_wr_d, s1_wi_q, s1_wi_d;

  logic                     s2_valid_q, s2_valid_d, s2_conj_q, s2_conj_d, s2_last_q, s2_last_d;
  logic signed [PP_W-1:0]   s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
  logic signed [PP_W-1:0]   s2_ir_q, s2_ir_d, s2_ri_q, s2_ri_d;

  logic                     s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
  logic signed [P-1:0]      s3_re_q, s3_re_d, s3_im_q, s3_im_d;

  logic                     out_valid_q, out_valid_d, out_last_q, out_last_d, ovf_q, ovf_d;
  logic [OUT_W-1:0]         out_re_q, out_re_d, out_im_q, out_im_d;

  logic [OUT_W-1:0]         rs_re_s, rs_im_s;
  logic                     rs_re_ovf_s, rs_im_ovf_s, ovf_set_s;

  assign en_s = ~out_valid_q | out_ready_i;

  fft_round_sat #(.P(P), .SHIFT(TW_W - 1), .OUT_W(OUT_W)) u_rs_re (
    .val_i (s3_re_q),
    .res_o (rs_re_s),
    .ovf_o (rs_re_ovf_s)
  );

  fft_round_sat #(.P(P), .SHIFT(TW_W - 1), .OUT_W(OUT_W)) u_rs_im (
    .val_i (s3_im_q),
    .res_o (rs_im_s),
    .ovf_o (rs_im_ovf_s)
  );

  // Next-state for all stages: everything advances together on en_s, otherwise holds.
  always_comb begin
    s1_valid_d = en_s ? in_valid_i : s1_valid_q;
    s1_conj_d  = en_s ? conj_i     : s1_conj_q;
    s1_last_d  = en_s ? last_i     : s1_last_q;
    s1_ar_d    = en_s ? data_i[2*DATA_W-1:DATA_W] : s1_ar_q;
    s1_ai_d    = en_s ? data_i[DATA_W-1:0]        : s1_ai_q;
    s1_wr_d    = en_s ? tw_i[2*TW_W-1:TW_W]       : s1_wr_q;
    s1_wi_d    = en_s ? tw_i[TW_W-1:0]            : s1_wi_q;

    s2_valid_d = en_s ? s1_valid_q : s2_valid_q;
    s2_conj_d  = en_s ? s1_conj_q  : s2_conj_q;
    s2_last_d  = en_s ? s1_last_q  : s2_last_q;
    s2_rr_d    = en_s ? PP_W'(s1_ar_q) * PP_W'(s1_wr_q) : s2_rr_q;
    s2_ii_d    = en_s ? PP_W'(s1_ai_q) * PP_W'(s1_wi_q) : s2_ii_q;
    s2_ir_d    = en_s ? PP_W'(s1_ai_q) * PP_W'(s1_wr_q) : s2_ir_q;
    s2_ri_d    = en_s ? PP_W'(s1_ar_q) * PP_W'(s1_wi_q) : s2_ri_q;

    // Conjugation swaps the add/sub signs so the twiddle itself is never negated.
    s3_valid_d = en_s ? s2_valid_q : s3_valid_q;
    s3_last_d  = en_s ? s2_last_q  : s3_last_q;
    s3_re_d    = en_s ? (s2_conj_q ? P'(s2_rr_q) + P'(s2_ii_q) : P'(s2_rr_q) - P'(s2_ii_q))
                      : s3_re_q;
    s3_im_d    = en_s ? (s2_conj_q ? P'(s2_ir_q) - P'(s2_ri_q) : P'(s2_ir_q) + P'(s2_ri_q))
                      : s3_im_q;

    out_valid_d = en_s ? s3_valid_q : out_valid_q;
    out_last_d  = en_s ? s3_last_q  : out_last_q;
    out_re_d    = en_s ? rs_re_s    : out_re_q;
    out_im_d    = en_s ? rs_im_s    : out_im_q;

    ovf_set_s   = en_s & s3_valid_q & (rs_re_ovf_s | rs_im_ovf_s);
    ovf_d       = ovf_set_s | (ovf_q & ~clr_ovf_i);
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_conj_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_ar_q     <= '0;
      s1_ai_q     <= '0;
      s1_wr_q     <= '0;
      s1_wi_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_conj_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_rr_q     <= '0;
      s2_ii_q     <= '0;
      s2_ir_q     <= '0;
      s2_ri_q     <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_re_q     <= '0;
      s3_im_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_conj_q   <= s1_conj_d;
      s1_last_q   <= s1_last_d;
      s1_ar_q     <= s1_ar_d;
      s1_ai_q     <= s1_ai_d;
      s1_wr_q     <= s1_wr_d;
      s1_wi_q     <= s1_wi_d;
      s2_valid_q  <= s2_valid_d;
      s2_conj_q   <= s2_conj_d;
      s2_last_q   <= s2_last_d;
      s2_rr_q     <= s2_rr_d;
      s2_ii_q     <= s2_ii_d;
      s2_ir_q     <= s2_ir_d;
      s2_ri_q     <= s2_ri_d;
      s3_valid_q  <= s3_valid_d;
      s3_last_q   <= s3_last_d;
      s3_re_q     <= s3_re_d;
      s3_im_q     <= s3_im_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready_o  = en_s;
  assign out_valid_o = out_valid_q;
  assign data_o      = {out_re_q, out_im_q};
  assign last_o      = out_last_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fft_cmult_pipe.sv
// Self-checking bench for fft_cmult_pipe: directed literal cases plus randomized
// traffic checked every cycle against an arithmetic reference model.
module tb_fft_cmult_pipe;

  localparam int DW = 25;
  localparam int TW = 18;
  localparam int OW = 25;

  logic              clk = 1'b0;
  logic              rst_ni, in_valid_i, in_ready_o, conj_i, last_i;
  logic              out_valid_o, out_ready_i, last_o, ovf_o, clr_ovf_i;
  logic [2*DW-1:0]   data_i;
  logic [2*TW-1:0]   tw_i;
  logic [2*OW-1:0]   data_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  typedef struct {
    logic [2*OW-1:0] d;
    logic            last;
    logic            ovf;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  logic ovf_seen = 1'b0;

  always #5 clk = ~clk;

  fft_cmult_pipe dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .data_i(data_i), .tw_i(tw_i), .conj_i(conj_i), .last_i(last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .data_o(data_o),
    .last_o(last_o), .ovf_o(ovf_o), .clr_ovf_i(clr_ovf_i)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Round half up, drop TW-1 fraction bits, then clamp or wrap to OW bits.
  function automatic longint reduce(input longint s, output bit ov);
    longint mx = (longint'(1) <<< (OW - 1)) - 1;
    longint mn = -mx - 1;
    longint r  = (s + (longint'(1) <<< (TW - 2))) >>> (TW - 1);
    ov = (r > mx) || (r < mn);
`ifdef FFT_CMULT_SAT_EN
    if (r > mx) r = mx;
    else if (r < mn) r = mn;
`else
    r = r & ((longint'(1) <<< OW) - 1);
    if (r > mx) r = r - (longint'(1) <<< OW);
`endif
    return r;
  endfunction

  function automatic logic [2*DW-1:0] pd(input longint re, input longint im);
    return {DW'(re), DW'(im)};
  endfunction

  function automatic logic [2*TW-1:0] pt(input longint re, input longint im);
    return {TW'(re), TW'(im)};
  endfunction

  function automatic logic [2*OW-1:0] po(input longint re, input longint im);
    return {OW'(re), OW'(im)};
  endfunction

  function automatic exp_t model(input logic [2*DW-1:0] d, input logic [2*TW-1:0] t,
                                 input logic c, input logic l);
    longint ar = longint'($signed(d[2*DW-1:DW]));
    longint ai = longint'($signed(d[DW-1:0]));
    longint wr = longint'($signed(t[2*TW-1:TW]));
    longint wi = longint'($signed(t[TW-1:0]));
    longint re_s, im_s, re, im;
    bit ov_r, ov_i;
    exp_t e;
    re_s = c ? (ar * wr + ai * wi) : (ar * wr - ai * wi);
    im_s = c ? (ai * wr - ar * wi) : (ai * wr + ar * wi);
    re = reduce(re_s, ov_r);
    im = reduce(im_s, ov_i);
    e.d = po(re, im);
    e.last = l;
    e.ovf = ov_r | ov_i;
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd_d();
    logic [31:0] r = $urandom();
    case ($urandom_range(7))
      0: return {1'b1, {(DW-1){1'b0}}};
      1: return {1'b0, {(DW-1){1'b1}}};
      default: return r[DW-1:0];
    endcase
  endfunction

  function automatic logic [TW-1:0] rnd_t();
    logic [31:0] r = $urandom();
    case ($urandom_range(7))
      0: return {1'b1, {(TW-1){1'b0}}};
      1: return {1'b0, {(TW-1){1'b1}}};
      default: return r[TW-1:0];
    endcase
  endfunction

  // Compare process: scoreboard of accepted inputs versus every output transfer.
  always @(negedge clk) begin
    if (!rst_ni) begin
      q.delete();
      ovf_seen = 1'b0;
    end else begin
      chk("in_ready_o", 64'(in_ready_o), 64'(!out_valid_o || out_ready_i));
      if (q.size() == 0) begin
        chk("out_valid_o idle", 64'(out_valid_o), 64'd0);
        chk("ovf_o", 64'(ovf_o), 64'(ovf_seen));
      end else if (out_valid_o) begin
        chk("ovf_o", 64'(ovf_o), 64'(ovf_seen | q[0].ovf));
        if (out_ready_i) begin
          e_mon = q.pop_front();
          chk("data_o", 64'(data_o), 64'(e_mon.d));
          chk("last_o", 64'(last_o), 64'(e_mon.last));
          ovf_seen = ovf_seen | e_mon.ovf;
          n_pop++;
        end
      end else begin
        chk("ovf_o", 64'(ovf_o), 64'(ovf_seen));
      end
      if (clr_ovf_i) ovf_seen = 1'b0;
      if (in_valid_i && in_ready_o) q.push_back(model(data_i, tw_i, conj_i, last_i));
    end
  end

  task automatic drive(input logic [2*DW-1:0] d, input logic [2*TW-1:0] t,
                       input logic c, input logic l);
    in_valid_i = 1'b1;
    data_i = d;
    tw_i = t;
    conj_i = c;
    last_i = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    chk("ovf cleared", 64'(ovf_o), 64'd0);
  endtask

  task automatic drive_stream(input int n, input int valid_pct, input int ready_pct, input bit bp);
    int sent = 0;
    int cyc = 0;
    int budget = n * 20 + 100;
    int w = 0;
    bit have = 1'b0;
    while (sent < n && cyc < budget) begin
      if (!have && $urandom_range(99) < valid_pct) begin
        data_i = {rnd_d(), rnd_d()};
        tw_i = {rnd_t(), rnd_t()};
        conj_i = 1'($urandom_range(1));
        last_i = 1'($urandom_range(1));
        have = 1'b1;
      end
      in_valid_i = have;
      out_ready_i = bp ? ((cyc < 3) || (cyc > 5)) : ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (have && in_ready_o) begin
        sent++;
        have = 1'b0;
      end
      tick();
      cyc++;
    end
    if (sent < n) chk("stream timeout", 64'(sent), 64'(n));
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    while (q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    chk("drain empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int base;
    exp_t m;
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    data_i = '0;
    tw_i = '0;
    conj_i = 1'b0;
    last_i = 1'b0;
    out_ready_i = 1'b1;
    clr_ovf_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid_o", 64'(out_valid_o), 64'd0);
    chk("rst last_o", 64'(last_o), 64'd0);
    chk("rst ovf_o", 64'(ovf_o), 64'd0);
    chk("rst data_o", 64'(data_o), 64'd0);
    chk("rst in_ready_o", 64'(in_ready_o), 64'd1);

    // Pin the reference model to hand-computed results.
    m = model(pd(1000, -2000), pt(131071, 0), 1'b0, 1'b0);
    chk("model identity", 64'(m.d), 64'(po(1000, -2000)));
    m = model(pd(100, 200), pt(0, -131072), 1'b0, 1'b0);
    chk("model rot", 64'(m.d), 64'(po(200, -100)));
    m = model(pd(100, 200), pt(0, -131072), 1'b1, 1'b0);
    chk("model rot conj", 64'(m.d), 64'(po(-200, 100)));
    m = model(pd(-16777216, -16777216), pt(-131072, -131072), 1'b0, 1'b0);
`ifdef FFT_CMULT_SAT_EN
    chk("model ovf", 64'(m.d), 64'(po(0, 16777215)));
`else
    chk("model ovf", 64'(m.d), 64'(po(0, 0)));
`endif
    chk("model ovf flag", 64'(m.ovf), 64'd1);

    // Identity with latency: accepted on the first edge after release.
    rst_ni = 1'b1;
    drive(pd(1000, -2000), pt(131071, 0), 1'b0, 1'b0);
    tick();
    in_valid_i = 1'b0;
    chk("lat N", 64'(out_valid_o), 64'd0);
    tick();
    chk("lat N+1", 64'(out_valid_o), 64'd0);
    tick();
    chk("lat N+2", 64'(out_valid_o), 64'd0);
    tick();
    chk("lat N+3 valid", 64'(out_valid_o), 64'd1);
    chk("identity data", 64'(data_o), 64'(po(1000, -2000)));
    chk("identity ovf", 64'(ovf_o), 64'd0);

    // Rotation, second sample tagged last.
    drive(pd(100, 200), pt(0, -131072), 1'b0, 1'b0);
    tick();
    drive(pd(100, 200), pt(0, -131072), 1'b1, 1'b1);
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    chk("rot data", 64'(data_o), 64'(po(200, -100)));
    chk("rot last", 64'(last_o), 64'd0);
    tick();
    chk("rot conj data", 64'(data_o), 64'(po(-200, 100)));
    chk("rot conj last", 64'(last_o), 64'd1);

    // Overflow and sticky flag.
    tick();
    drive(pd(-16777216, -16777216), pt(-131072, -131072), 1'b0, 1'b0);
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    tick();
`ifdef FFT_CMULT_SAT_EN
    chk("ovf data", 64'(data_o), 64'(po(0, 16777215)));
`else
    chk("ovf data", 64'(data_o), 64'(po(0, 0)));
`endif
    chk("ovf set", 64'(ovf_o), 64'd1);
    repeat (3) tick();
    chk("ovf sticky", 64'(ovf_o), 64'd1);
    clr_pulse();

    // Backpressure mid-stream.
    base = n_pop;
    drive_stream(6, 100, 100, 1'b1);
    chk("bp count", 64'(n_pop - base), 64'd6);

    // Reset with samples in flight.
    drive(pd(-16777216, -16777216), pt(-131072, -131072), 1'b0, 1'b1);
    tick();
    repeat (3) begin
      drive(pd(100, 200), pt(0, -131072), 1'b0, 1'b1);
      tick();
    end
    in_valid_i = 1'b0;
    chk("pre-rst valid", 64'(out_valid_o), 64'd1);
    chk("pre-rst ovf", 64'(ovf_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid-rst valid", 64'(out_valid_o), 64'd0);
    chk("mid-rst last", 64'(last_o), 64'd0);
    chk("mid-rst ovf", 64'(ovf_o), 64'd0);
    chk("mid-rst data", 64'(data_o), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    drive(pd(100, 200), pt(0, -131072), 1'b0, 1'b0);
    tick();
    in_valid_i = 1'b0;
    chk("post-rst N", 64'(out_valid_o), 64'd0);
    tick();
    chk("post-rst N+1", 64'(out_valid_o), 64'd0);
    tick();
    chk("post-rst N+2", 64'(out_valid_o), 64'd0);
    tick();
    chk("post-rst valid", 64'(out_valid_o), 64'd1);
    chk("post-rst data", 64'(data_o), 64'(po(200, -100)));
    tick();
    chk("post-rst single", 64'(out_valid_o), 64'd0);

    // Randomized traffic, flag cleared between halves.
    drive_stream(5000, 70, 70, 1'b0);
    clr_pulse();
    drive_stream(5000, 70, 70, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_cmult_pipe.md
# fft_cmult_pipe

Parametrised, fully pipelined complex multiplier for the FFT butterfly datapath. It multiplies a complex sample by a complex twiddle factor, or by its conjugate for inverse transforms. Products are rounded and scaled back to sample width, with valid/ready flow control and frame-last sideband. It sits between the twiddle ROM/stage buffer and the butterfly adder in every FFT stage, and supersedes the fixed-width multiplier.

## Interface
Parameters:
- DATA_W, 25, signed width of each sample component (re, im)
- TW_W, 18, signed width of each twiddle component, format Q1.(TW_W-1)
- OUT_W, DATA_W, signed width of each output component

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  input sample/twiddle valid
- in_ready_o  out  1  block accepts input this cycle
- data_i  in  2*DATA_W  sample, {re, im}, re in MSBs
- tw_i  in  2*TW_W  twiddle, {re, im}, re in MSBs
- conj_i  in  1  1 = multiply by conj(tw), sampled with data
- last_i  in  1  frame-last tag, carried with data
- out_valid_o  out  1  output valid
- out_ready_i  in  1  downstream accepts output
- data_o  out  2*OUT_W  product, {re, im}
- last_o  out  1  delayed last_i
- ovf_o  out  1  sticky overflow flag
- clr_ovf_i  in  1  synchronous clear of ovf_o

## Operation
- Transfer on input when in_valid_i & in_ready_o; on output when out_valid_o & out_ready_i.
- 4 register stages: S1 input capture (data, tw, conj, last); S2 four partial products ar*wr, ai*wi, ai*wr, ar*wi; S3 add/sub; S4 round, scale, saturate → data_o.
- S3 non-conj: re = ar*wr − ai*wi, im = ai*wr + ar*wi. S3 conj: re = ar*wr + ai*wi, im = ai*wr − ar*wi. The twiddle is never negated explicitly, so wi = −2^(TW_W−1) is safe.
- Internal width P = DATA_W+TW_W+1, no overflow possible before S4.
- S4: add 2^(TW_W−2), then arithmetic shift right by TW_W−1 (round-half-up toward +∞), then reduce to OUT_W.
- Out-of-range on either component in a transferring S4 cycle sets ovf_o. ovf_o stays set until clr_ovf_i; a clear and a new overflow in the same cycle leave ovf_o at 1.
- Per-stage valid bits travel with the data; last_o is aligned to data_o.

## Timing
- Global advance enable en = ~out_valid_o | out_ready_i. All stages, including the valid bits, update only when en = 1.
- in_ready_o = en (combinational from out_valid_o/out_ready_i). There is no combinational path from in_valid_i to any output.
- Latency: sample accepted at edge N drives data_o/out_valid_o after edge N+3 when no stall occurs. Throughput is 1/cycle.
- Bubbles are not compressed: an empty stage still costs a cycle.
- Stall (out_valid_o=1, out_ready_i=0): every register holds, in_ready_o=0, data_o stable until accepted.
- Reset (asynchronous, mid-stream included): all valid bits, out_valid_o, last_o and ovf_o go to 0; data_o goes to 0. In-flight samples are discarded.
- First transfer after reset release is possible on the first rising edge with rst_ni high.

## Configuration
- FFT_CMULT_SAT_EN defined: S4 clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1] on overflow.
- FFT_CMULT_SAT_EN undefined: S4 takes the low OUT_W bits (two's-complement wrap); overflow detection and ovf_o are unchanged.

## Structure
- Package fft_pkg holds the shared items:
  - typedef cplx_t for the sample, and the twiddle format constants
  - rounding helper function
  - default widths: DATA_W=25, TW_W=18
- Sub-module fft_round_sat performs S4 combinationally (round, shift, saturate/wrap, overflow flag). It is parameterised by P, shift and OUT_W and is reusable by the butterfly adder.

## Test plan
- Identity-like: DATA_W=25, TW_W=18; data=(1000,−2000), tw=(131071,0), conj=0 → data_o=(1000,−2000) after edge N+3, ovf_o=0.
- Rotation: data=(100,200), tw=(0,−131072); conj=0 → (200,−100); conj=1 → (−200,100). last_i=1 on the second sample appears on last_o with it.
- Overflow: data=(−2^24,−2^24), tw=(−131072,−131072), conj=0 → re=0 and ovf_o=1. With FFT_CMULT_SAT_EN, im=16777215; without it, im=0. clr_ovf_i pulse → ovf_o=0 next cycle.
- Backpressure: 6 back-to-back inputs with out_ready_i low for 3 cycles mid-stream → all 6 outputs in order, none duplicated; in_ready_o low exactly while out_valid_o & ~out_ready_i.
- Reset mid-stream: rst_ni asserted with 3 samples in flight → out_valid_o, last_o, ovf_o and data_o are 0 immediately. After release, a new sample yields only its own result 4 cycles later.
- Random: 10k random data/tw/conj with random valid/ready versus a reference model including rounding and the saturate/wrap mode → zero mismatches.
